ei_tdp_ram_arbiter: RTL and testbench

- Round-robin arbiter that shares one true-dual-port RAM between NUM_REQ requesters.
- Accepts up to two requests per cycle and issues the first on RAM port A, the second on port B.
- Rejects same-cycle address collisions that the dual-port RAM cannot resolve deterministically.
- Returns read data to the originating requester with a fixed latency. Sits directly in front of the TDP RAM in the UVC DUT wrapper.

---
 rtl/ei_tdp_ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ei_tdp_ram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ei_tdp_ram_arbiter.sv
// Round-robin arbiter sharing one true-dual-port RAM between NUM_REQ requesters.
// Up to two requests are issued per cycle (port A, port B); read data returns two cycles after accept.
module ei_tdp_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
  output logic [ADDR_WIDTH-1:0]          addr_a,
  output logic [ADDR_WIDTH-1:0]          addr_b,
  output logic [DATA_WIDTH-1:0]          data_a,
  output logic [DATA_WIDTH-1:0]          data_b,
  output logic                           we_a,
  output logic                           we_b,
  output logic                           re_a,
  output logic                           re_b,
  input  logic [DATA_WIDTH-1:0]          q_a,
  input  logic [DATA_WIDTH-1:0]          q_b,
  output logic [15:0]                    coll_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a request transfers on a posedge where req_valid[i] && req_ready[i];
  // the requester holds valid/we/addr/wdata stable until then. req_ready is combinational.

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      g0;
  logic [IDX_W-1:0]      g1;
  logic                  g0_found;
  logic                  g1_found;
  logic                  collide;
  logic                  grant0;
  logic                  grant1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  we0;
  logic                  we1;

  logic [IDX_W-1:0]      tag_a;
  logic [IDX_W-1:0]      tag_b;
  logic [IDX_W-1:0]      sel_a;
  logic [IDX_W-1:0]      sel_b;
  logic                  out_a;
  logic                  out_b;
  logic [NUM_REQ-1:0]    rsp_next;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Cyclic scan from rr_ptr: first valid requester is g0, the next one is g1.
  always_comb begin
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0       = '0;
    g1       = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = next_idx(rr_ptr, k);
      if (req_valid[cand]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0       = cand;
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1       = cand;
        end
      end
    end
  end

  assign addr0  = req_addr[int'(g0)*ADDR_WIDTH +: ADDR_WIDTH];
  assign addr1  = req_addr[int'(g1)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata0 = req_wdata[int'(g0)*DATA_WIDTH +: DATA_WIDTH];
  assign wdata1 = req_wdata[int'(g1)*DATA_WIDTH +: DATA_WIDTH];
  assign we0    = req_we[g0];
  assign we1    = req_we[g1];

  // Same-address access involving a write has no deterministic outcome in the TDP RAM.
  assign collide = g0_found && g1_found && (addr0 == addr1) && (we0 || we1);
  assign grant0  = g0_found;
  assign grant1  = g1_found && !collide;

  always_comb begin
    req_ready = '0;
    if (resetn) begin
      if (grant0) req_ready[g0] = 1'b1;
      if (grant1) req_ready[g1] = 1'b1;
    end
  end

  always_comb begin
    rsp_next = '0;
    if (re_a) rsp_next[tag_a] = 1'b1;
    if (re_b) rsp_next[tag_b] = 1'b1;
  end

  // RAM output is steered to the requester whose read tag reached the second stage.
  always_comb begin
    rsp_rdata = '0;
    if (out_a) rsp_rdata[int'(sel_a)*DATA_WIDTH +: DATA_WIDTH] = q_a;
    if (out_b) rsp_rdata[int'(sel_b)*DATA_WIDTH +: DATA_WIDTH] = q_b;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_a    <= '0;
      addr_b    <= '0;
      data_a    <= '0;
      data_b    <= '0;
      we_a      <= 1'b0;
      we_b      <= 1'b0;
      re_a      <= 1'b0;
      re_b      <= 1'b0;
      tag_a     <= '0;
      tag_b     <= '0;
      sel_a     <= '0;
      sel_b     <= '0;
      out_a     <= 1'b0;
      out_b     <= 1'b0;
      rsp_valid <= '0;
      rr_ptr    <= '0;
      coll_cnt  <= '0;
    end else begin
      if (grant0) begin
        addr_a <= addr0;
        data_a <= wdata0;
        we_a   <= we0;
        re_a   <= !we0;
        tag_a  <= g0;
      end else begin
        we_a <= 1'b0;
        re_a <= 1'b0;
      end

      if (grant1) begin
        addr_b <= addr1;
        data_b <= wdata1;
        we_b   <= we1;
        re_b   <= !we1;
        tag_b  <= g1;
      end else begin
        we_b <= 1'b0;
        re_b <= 1'b0;
      end

      sel_a     <= tag_a;
      sel_b     <= tag_b;
      out_a     <= re_a;
      out_b     <= re_b;
      rsp_valid <= rsp_next;

      if (grant1)      rr_ptr <= next_idx(g1, 1);
      else if (grant0) rr_ptr <= next_idx(g0, 1);

      if (collide && (coll_cnt != 16'hFFFF)) coll_cnt <= coll_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ei_tdp_ram_arbiter.sv
// Bench for ei_tdp_ram_arbiter: reset checks, a vector table, directed corner sequences and
// randomized traffic against a queue-based reference model, with a behavioural TDP RAM attached.
module tb_ei_tdp_ram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [39:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [9:0]  addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic        we_a, we_b, re_a, re_b;
  logic [7:0]  q_a, q_b;
  logic [15:0] coll_cnt;

  ei_tdp_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_REQ(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .we_a(we_a), .we_b(we_b), .re_a(re_a), .re_b(re_b),
    .q_a(q_a), .q_b(q_b), .coll_cnt(coll_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural TDP RAM (registered read) ----------------
  logic [7:0] ram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    ram[10'h020] = 8'h77;
    q_a = 8'h00;
    q_b = 8'h00;
    forever begin
      @(posedge clk);
      if (we_a) ram[addr_a] <= data_a;
      if (re_a) q_a <= ram[addr_a];
      if (we_b) ram[addr_b] <= data_b;
      if (re_b) q_b <= ram[addr_b];
    end
  end

  // ---------------- scoreboard / reference model state ----------------
  int          pass_cnt;
  int          chk_cnt;
  int          cyc;
  int          m_ptr;
  int          m_coll;
  logic [7:0]  ref_mem [1024];
  logic [9:0]  m_addr_a, m_addr_b;
  logic [7:0]  m_data_a, m_data_b;
  logic        m_we_a, m_we_b, m_re_a, m_re_b;
  logic [3:0]  m_ready;
  logic [3:0]  sampled_ready;
  logic [27:0] exp_q[$];  // {due cycle[15:0], requester[3:0], data[7:0]}

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [39:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rsp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_coll;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [9:0] a_of(input int i);
    return req_addr[i*10 +: 10];
  endfunction

  function automatic logic [7:0] d_of(input int i);
    return req_wdata[i*8 +: 8];
  endfunction

  // Reference arbitration: list the valid requesters in round-robin order, take the first two.
  function automatic void model_arb(output logic [3:0] rdy, output int ga, output int gb, output bit col);
    int order[$];
    rdy = 4'b0000;
    ga  = -1;
    gb  = -1;
    col = 1'b0;
    for (int k = 0; k < 4; k++)
      if (req_valid[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    if (order.size() >= 1) ga = order[0];
    if (order.size() >= 2) begin
      if ((a_of(order[0]) == a_of(order[1])) && (req_we[order[0]] || req_we[order[1]])) col = 1'b1;
      else gb = order[1];
    end
    if (ga >= 0) rdy[ga] = 1'b1;
    if (gb >= 0) rdy[gb] = 1'b1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 0;
    m_coll = 0;
    m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
    m_we_a = 1'b0; m_we_b = 1'b0; m_re_a = 1'b0; m_re_b = 1'b0;
  endtask

  // One clock: starts and ends just after a negedge with the inputs already driven.
  task automatic step();
    logic [3:0]  rdy;
    int          ga, gb, idx;
    bit          col;
    logic [7:0]  da, db;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [27:0] e;
    #1;
    model_arb(rdy, ga, gb, col);
    m_ready       = rdy;
    sampled_ready = req_ready;
    check("req_ready", 32'(req_ready), 32'(rdy));
    @(posedge clk);
    cyc++;
    da = (ga >= 0) ? ref_mem[a_of(ga)] : 8'h00;
    db = (gb >= 0) ? ref_mem[a_of(gb)] : 8'h00;
    if (ga >= 0) begin
      m_we_a = req_we[ga]; m_re_a = !req_we[ga]; m_addr_a = a_of(ga); m_data_a = d_of(ga);
      if (!req_we[ga]) exp_q.push_back({16'(cyc + 1), 4'(ga), da});
    end else begin
      m_we_a = 1'b0; m_re_a = 1'b0;
    end
    if (gb >= 0) begin
      m_we_b = req_we[gb]; m_re_b = !req_we[gb]; m_addr_b = a_of(gb); m_data_b = d_of(gb);
      if (!req_we[gb]) exp_q.push_back({16'(cyc + 1), 4'(gb), db});
    end else begin
      m_we_b = 1'b0; m_re_b = 1'b0;
    end
    if (ga >= 0 && req_we[ga]) ref_mem[a_of(ga)] = d_of(ga);
    if (gb >= 0 && req_we[gb]) ref_mem[a_of(gb)] = d_of(gb);
    if (gb >= 0)      m_ptr = (gb + 1) % 4;
    else if (ga >= 0) m_ptr = (ga + 1) % 4;
    if (col && m_coll < 65535) m_coll++;
    @(negedge clk);
    check("we_a", 32'(we_a), 32'(m_we_a));
    check("re_a", 32'(re_a), 32'(m_re_a));
    check("addr_a", 32'(addr_a), 32'(m_addr_a));
    check("data_a", 32'(data_a), 32'(m_data_a));
    check("we_b", 32'(we_b), 32'(m_we_b));
    check("re_b", 32'(re_b), 32'(m_re_b));
    check("addr_b", 32'(addr_b), 32'(m_addr_b));
    check("data_b", 32'(data_b), 32'(m_data_b));
    check("coll_cnt", 32'(coll_cnt), 32'(m_coll));
    ev = 4'b0000;
    ed = 32'h0;
    while (exp_q.size() > 0 && exp_q[0][27:12] == 16'(cyc)) begin
      e   = exp_q.pop_front();
      idx = int'(e[11:8]);
      ev[idx] = 1'b1;
      ed[idx*8 +: 8] = e[7:0];
    end
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("rsp_rdata", rsp_rdata, ed);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    pass_cnt = 0; chk_cnt = 0; cyc = 0;
    resetn = 1'b0;
    req_valid = 4'hF; req_we = 4'h0; req_addr = '0; req_wdata = '0;
    model_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i);
    ref_mem[10'h020] = 8'h77;

    //                 valid  we      addr {a3,a2,a1,a0}                        wdata          ready   rsp     rdata          coll
    tbl[0]  = '{4'hF, 4'h0, {10'h004, 10'h003, 10'h002, 10'h001}, 32'h0,         4'b0011, 4'b0000, 32'h0000_0000, 16'd0};
    tbl[1]  = '{4'hC, 4'h0, {10'h004, 10'h003, 10'h000, 10'h000}, 32'h0,         4'b1100, 4'b0011, 32'h0000_0201, 16'd0};
    tbl[2]  = '{4'h8, 4'h0, {10'h005, 10'h000, 10'h000, 10'h000}, 32'h0,         4'b1000, 4'b1100, 32'h0403_0000, 16'd0};
    tbl[3]  = '{4'h9, 4'h0, {10'h006, 10'h000, 10'h000, 10'h007}, 32'h0,         4'b1001, 4'b1000, 32'h0500_0000, 16'd0};
    tbl[4]  = '{4'h6, 4'h2, {10'h000, 10'h010, 10'h010, 10'h000}, 32'h0000_3C00, 4'b0010, 4'b1001, 32'h0600_0007, 16'd1};
    tbl[5]  = '{4'h4, 4'h0, {10'h000, 10'h010, 10'h010, 10'h000}, 32'h0,         4'b0100, 4'b0000, 32'h0000_0000, 16'd1};
    tbl[6]  = '{4'h9, 4'h0, {10'h020, 10'h000, 10'h000, 10'h020}, 32'h0,         4'b1001, 4'b0100, 32'h003C_0000, 16'd1};
    tbl[7]  = '{4'h3, 4'h1, {10'h000, 10'h000, 10'h030, 10'h030}, 32'h0000_0099, 4'b0010, 4'b1001, 32'h7700_0077, 16'd2};
    tbl[8]  = '{4'h1, 4'h1, {10'h000, 10'h000, 10'h030, 10'h030}, 32'h0000_0099, 4'b0001, 4'b0010, 32'h0000_3000, 16'd2};
    tbl[9]  = '{4'hF, 4'hC, {10'h040, 10'h040, 10'h008, 10'h030}, 32'h2211_0000, 4'b0110, 4'b0000, 32'h0000_0000, 16'd2};
    tbl[10] = '{4'h9, 4'h8, {10'h040, 10'h040, 10'h008, 10'h030}, 32'h2211_0000, 4'b1001, 4'b0010, 32'h0000_0800, 16'd2};
    tbl[11] = '{4'h0, 4'h0, {10'h000, 10'h000, 10'h000, 10'h000}, 32'h0,         4'b0000, 4'b0001, 32'h0000_0099, 16'd2};

    // Reset state with every requester asking
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_ports", 32'({we_a, we_b, re_a, re_b}), 32'h0);
    check("rst_addr", 32'({addr_a, addr_b}), 32'h0);
    check("rst_data", 32'({data_a, data_b}), 32'h0);
    check("rst_coll", 32'(coll_cnt), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);

    // Idle after release
    req_valid = 4'h0;
    resetn    = 1'b1;
    repeat (10) begin
      step();
      check("idle_ports", 32'({we_a, we_b, re_a, re_b}), 32'h0);
    end

    // Vector table
    for (int r = 0; r < 12; r++) begin
      req_valid = tbl[r].valid;
      req_we    = tbl[r].we;
      req_addr  = tbl[r].addr;
      req_wdata = tbl[r].wdata;
      step();
      check("tbl_ready", 32'(sampled_ready), 32'(tbl[r].exp_ready));
      check("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[r].exp_rsp));
      check("tbl_rsp_rdata", rsp_rdata, tbl[r].exp_rdata);
      check("tbl_coll", 32'(coll_cnt), 32'(tbl[r].exp_coll));
    end

    // R0 writes A5 @003 then reads it back
    req_valid = 4'h1; req_we = 4'h1; req_addr = 40'h003; req_wdata = 32'hA5;
    step();
    check("wr_we_a", 32'(we_a), 32'h1);
    check("wr_addr_a", 32'(addr_a), 32'h003);
    check("wr_data_a", 32'(data_a), 32'hA5);
    req_we = 4'h0;
    step();
    check("rd_re_a", 32'(re_a), 32'h1);
    req_valid = 4'h0;
    step();
    check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_rdata0", 32'(rsp_rdata[7:0]), 32'hA5);
    step();
    check("rd_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Reset while a read from R2 is in flight
    req_valid = 4'h4; req_we = 4'h0; req_addr = {10'h000, 10'h005, 10'h000, 10'h000};
    step();
    req_valid = 4'h0;
    resetn    = 1'b0;
    #1;
    model_reset();
    check("mid_rst_ports", 32'({we_a, we_b, re_a, re_b}), 32'h0);
    check("mid_rst_addr", 32'({addr_a, addr_b}), 32'h0);
    check("mid_rst_coll", 32'(coll_cnt), 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_rsp", 32'(rsp_valid), 32'h0);
      check("mid_rst_rdata", rsp_rdata, 32'h0);
    end
    resetn    = 1'b1;
    req_valid = 4'hF;
    req_addr  = {10'h104, 10'h103, 10'h102, 10'h101};
    step();
    check("mid_rst_ptr", 32'(sampled_ready), 32'h3);
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
    repeat (4) begin
      req_valid = req_valid & ~m_ready;
      step();
    end

    // Randomized traffic, requests held until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i]         = 1'b1;
          req_we[i]            = ($urandom_range(0, 2) == 0);
          req_addr[i*10 +: 10] = 10'($urandom_range(0, 7));
          req_wdata[i*8 +: 8]  = 8'($urandom_range(0, 255));
        end
      end
      step();
      req_valid = req_valid & ~m_ready;
    end
    while (req_valid != 4'h0) begin
      step();
      req_valid = req_valid & ~m_ready;
    end
    repeat (3) step();
    check("drain_queue", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
